// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX cores.
//   uart_rx_state_e : receive FSM state encoding
//   OVERSAMPLE_DEF  : default oversample ticks per bit
//   MID_TICK        : oversample tick index at which a bit is sampled
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MID_TICK       = OVERSAMPLE_DEF / 2 - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the UART RX and TX cores.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   en_i   : enable; while low the counter is held at the reload value
//   clr_i  : restart the period (counter reloaded, no tick this cycle)
//   div_i  : tick period minus 1; sampled only at reload
//   tick_o : one-cycle tick every div_i+1 clocks
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = div_i;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = div_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx_i, oversamples it and deframes
// start/data/parity/stop, then emits exactly one outcome pulse per frame.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   rx_i                 : serial line (asynchronous, idle high)
//   rx_en_i              : receiver enable
//   clk_div_i            : oversample tick period minus 1
//   parity_en_i/odd_i    : parity present / odd parity select
//   buf_full_i           : RX buffer full
//   wdata_o, we_o        : received byte and one-cycle write strobe
//   frame_err_o          : stop bit sampled low
//   parity_err_o         : parity mismatch
//   overrun_o            : good byte dropped, buffer full
//   busy_o               : FSM not idle
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  rx_en_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  buf_full_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o,
  output logic                  frame_err_o,
  output logic                  parity_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

  uart_rx_state_e        state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  fe_q, fe_d;
  logic                  pe_q, pe_d;
  logic                  ov_q, ov_d;

  logic rx_s, fall, tick, tick_clr, mid;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign mid  = tick && (os_q == OS_MID);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (rx_en_i),
    .clr_i  (tick_clr),
    .div_i  (clk_div_i),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], rx_i};
    prev_d   = rx_s;
    os_d     = os_q;
    bc_d     = bc_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    ov_d     = 1'b0;
    tick_clr = 1'b0;

    if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;

    if (!rx_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d  = ST_START;
            os_d     = '0;
            tick_clr = 1'b1;
          end
        end
        ST_START: begin
          if (mid) begin
            state_d = rx_s ? ST_IDLE : ST_DATA;
            bc_d    = '0;
          end
        end
        ST_DATA: begin
          if (mid) begin
            shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
            if (bc_q == BC_LAST) state_d = parity_en_i ? ST_PARITY : ST_STOP;
            else                 bc_d    = bc_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (mid) begin
            par_d   = rx_s;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          // Return to IDLE at mid-stop so a start edge right after the
          // stop bit's second half is still caught.
          if (mid) begin
            state_d = ST_IDLE;
            if (!rx_s) begin
              fe_d = 1'b1;
            end else if (parity_en_i && ((^shreg_q ^ par_q) != parity_odd_i)) begin
              pe_d = 1'b1;
            end else if (buf_full_i) begin
              ov_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              wdata_d = shreg_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sync_q  <= '1;
      prev_q  <= 1'b1;
      os_q    <= '0;
      bc_q    <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      os_q    <= os_d;
      bc_q    <= bc_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ov_q    <= ov_d;
    end
  end

  assign wdata_o      = wdata_q;
  assign we_o         = we_q;
  assign frame_err_o  = fe_q;
  assign parity_err_o = pe_q;
  assign overrun_o    = ov_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
